// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage. Owns the PC, drives a 1-cycle
// synchronous imem, resolves J-type jumps locally, accepts execute
// redirects and buffers fetched words in a DEPTH-entry FIFO.
// Ports: clk, rst (async, active-high);
//   imem_req/imem_addr out, imem_rdata in (instruction memory);
//   instr_out/pc_out/instr_valid out, decode_ready in (decode);
//   redirect_valid/redirect_pc in (taken branch from execute).
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic        instr_valid,
  input  logic        decode_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic {S_RESET, S_RUN} state_t;

  state_t state;
  state_t state_nxt;
  logic   running;

  logic [31:0]   fetch_pc;
  logic [31:0]   req_pc;
  logic          resp_pending;
  logic [31:0]   buf_instr [DEPTH];
  logic [31:0]   buf_pc    [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;

  logic          accepted;
  logic          jump;
  logic          pop;
  logic [CW:0]   occ;
  logic [31:0]   req_pc_plus4;
  logic [31:0]   jump_target;
  logic [31:0]   redirect_target;
  logic [31:0]   next_addr;

  function automatic logic [PW-1:0] ptr_inc(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_RESET;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_RESET: state_nxt = S_RUN;
      S_RUN:   state_nxt = S_RUN;
    endcase
  end

  always_comb begin
    running = 1'b0;
    unique case (state)
      S_RESET: running = 1'b0;
      S_RUN:   running = 1'b1;
    endcase
  end

  assign redirect_target = redirect_pc & 32'hFFFF_FFFC;
  assign req_pc_plus4    = req_pc + 32'd4;
  assign jump_target     = (req_pc_plus4 & 32'hF000_0000)
                         | {4'b0, imem_rdata[25:0], 2'b00};

  // A redirect kills the response arriving in the same cycle,
  // including a jump word.
  assign accepted = resp_pending && !redirect_valid;
  assign jump     = accepted
                 && (imem_rdata[31:26] == 6'b110000);

  assign instr_valid = (count != '0) && !redirect_valid;
  assign pop         = instr_valid && decode_ready;

  // Occupancy after this cycle's push/pop. Requesting only when it
  // is below DEPTH leaves a slot for the response next cycle.
  assign occ = (CW+1)'(count) + (CW+1)'(accepted)
             - (CW+1)'(pop);
  assign imem_req = running && !redirect_valid
                 && (occ < (CW+1)'(DEPTH));

  always_comb begin
    next_addr = fetch_pc;
    unique case (1'b1)
      redirect_valid: next_addr = redirect_target;
      jump:           next_addr = jump_target;
      default:        next_addr = fetch_pc;
    endcase
  end

  assign imem_addr = next_addr;
  assign instr_out = instr_valid ? buf_instr[head] : '0;
  assign pc_out    = instr_valid ? buf_pc[head]    : '0;

  // Without a request, fetch_pc still captures a redirect or
  // jump target so it is used once space frees up.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc     <= RESET_PC;
      req_pc       <= '0;
      resp_pending <= 1'b0;
    end else begin
      resp_pending <= imem_req;
      if (imem_req) req_pc <= imem_addr;
      fetch_pc <= imem_req ? next_addr + 32'd4 : next_addr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (redirect_valid) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (accepted) tail <= ptr_inc(tail);
      if (pop)      head <= ptr_inc(head);
      count <= count + CW'(accepted) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (accepted) begin
      buf_instr[tail] <= imem_rdata;
      buf_pc[tail]    <= req_pc;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized scoreboard bench for fetch_unit.
// Program-order model predicts request and instruction streams.
module tb_fetch_unit;

  localparam logic [31:0] RPC    = 32'h0000_0000;
  localparam int          DEPTH  = 3;
  localparam int          STREAM = 300;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic        instr_valid;
  logic        decode_ready = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;

  int checks = 0;
  int fails  = 0;

  logic [31:0] exp_req_q [$];
  logic [31:0] exp_pc_q  [$];
  logic [31:0] exp_ins_q [$];
  logic [25:0] jmp_tab [logic [31:0]];

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .instr_out      (instr_out),
    .pc_out         (pc_out),
    .instr_valid    (instr_valid),
    .decode_ready   (decode_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  function automatic logic [31:0] word_at(input logic [31:0] a);
    if (jmp_tab.exists(a)) return {6'b110000, jmp_tab[a]};
    return {2'b00, a[31:2]};
  endfunction

  // Program order: a jump goes to its target, anything else to pc+4.
  function automatic logic [31:0] next_pc(input logic [31:0] a);
    logic [31:0] w;
    logic [31:0] p4;
    w  = word_at(a);
    p4 = a + 32'd4;
    if (w[31:26] == 6'b110000) return {p4[31:28], w[25:0], 2'b00};
    return p4;
  endfunction

  task automatic restart(input logic [31:0] pc);
    logic [31:0] p;
    p = {pc[31:2], 2'b00};
    exp_req_q.delete();
    exp_pc_q.delete();
    exp_ins_q.delete();
    for (int i = 0; i < STREAM; i++) begin
      exp_req_q.push_back(p);
      exp_pc_q.push_back(p);
      exp_ins_q.push_back(word_at(p));
      p = next_pc(p);
    end
  endtask

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Synchronous memory, 1-cycle latency; junk when idle.
  always @(posedge clk)
    imem_rdata <= imem_req ? word_at(imem_addr) : $urandom();

  // Monitor: every request and every pop is matched in order.
  always @(negedge clk) begin
    if (!rst) begin
      if (imem_req) begin
        if (exp_req_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL req_addr: got %h expected none", imem_addr);
        end else begin
          chk("req_addr", imem_addr, exp_req_q.pop_front());
        end
      end
      if (instr_valid && decode_ready) begin
        if (exp_pc_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL pc_out: got %h expected none", pc_out);
        end else begin
          chk("pc_out", pc_out, exp_pc_q.pop_front());
          chk("instr_out", instr_out, exp_ins_q.pop_front());
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_instr", instr_out, 32'd0);
    chk("rst_pc", pc_out, 32'd0);
    restart(RPC);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    decode_ready = 1'b1;
    @(negedge clk);
    chk("first_idle", {31'b0, imem_req}, 32'd0);
    @(negedge clk);
    chk("first_req", {31'b0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, RPC);
    repeat (2) @(negedge clk);
    chk("first_valid", {31'b0, instr_valid}, 32'd1);
    chk("first_pc", pc_out, RPC);
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    logic [31:0] tgt;
    tgt = {pc[31:2], 2'b00};
    @(posedge clk);
    #1 redirect_valid = 1'b1;
    redirect_pc = pc;
    restart(pc);
    @(negedge clk);
    chk("redir_valid", {31'b0, instr_valid}, 32'd0);
    chk("redir_no_req", {31'b0, imem_req}, 32'd0);
    @(posedge clk);
    #1 redirect_valid = 1'b0;
    redirect_pc = $urandom();
    @(negedge clk);
    chk("redir_req", {31'b0, imem_req}, 32'd1);
    chk("redir_addr", imem_addr, tgt);
  endtask

  initial begin
    int          found;
    int          gap;
    logic [31:0] addr;

    jmp_tab[32'h10] = 26'h40;
    for (int k = 0; k < 24; k++)
      jmp_tab[{20'b0, 10'($urandom_range(32'h200, 32'h2FF)), 2'b00}]
        = 26'($urandom_range(32'h200, 32'h2FF));

    do_reset();
    // Back-to-back requests, through the jump at 0x10.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("b2b_req", {31'b0, imem_req}, 32'd1);
    end

    // Five-cycle decode stall.
    @(posedge clk);
    #1 decode_ready = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("stall_no_req", {31'b0, imem_req}, 32'd0);
    chk("stall_valid", {31'b0, instr_valid}, 32'd1);
    @(posedge clk);
    #1 decode_ready = 1'b1;
    repeat (4) @(posedge clk);

    // Redirect in the cycle the jump word at 0x10 returns.
    do_redirect(32'h0);
    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      @(negedge clk);
      if (imem_req && imem_addr == 32'h10) found = 1;
    end
    chk("jump_req_seen", found, 32'd1);
    do_redirect(32'h400);

    // Redirect with two buffered and one in flight.
    repeat (3) @(posedge clk);
    @(posedge clk);
    #1 decode_ready = 1'b0;
    do_redirect(32'h203);
    decode_ready = 1'b1;
    repeat (6) @(posedge clk);

    // PC wrap past 0xFFFF_FFFC.
    do_redirect(32'hFFFF_FFF4);
    repeat (10) @(posedge clk);

    // Reset with the buffer full.
    @(posedge clk);
    #1 decode_ready = 1'b0;
    repeat (6) @(posedge clk);
    do_reset();
    repeat (4) @(posedge clk);

    // Random stalls and redirects.
    gap = 0;
    for (int c = 0; c < 1500; c++) begin
      if (c == 700) begin
        do_reset();
        gap = 0;
      end else if ($urandom_range(0, 24) == 0 || gap >= 100) begin
        if ($urandom_range(0, 1) == 1)
          addr = {20'b0, 10'($urandom_range(32'h200, 32'h2FF)),
                  2'($urandom())};
        else
          addr = $urandom();
        do_redirect(addr);
        gap = 0;
      end else begin
        @(posedge clk);
        #1 decode_ready = ($urandom_range(0, 3) != 0);
        gap++;
      end
    end

    @(posedge clk);
    #1 decode_ready = 1'b1;
    repeat (4) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
